// File: rtl/dop_tx_pkg.sv
// Shared definitions for the transducer burst generator: state encoding, divider
// tables and the limits used by the top-level configuration checks.
package dop_tx_pkg;

  localparam int unsigned CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  // Legacy-compatible state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StBurst  = 2'd1;
  localparam state_t StListen = 2'd2;

  // Half-period per frequency select, in mainclk cycles
  localparam int unsigned HALF_DIV0 = 32;
  localparam int unsigned HALF_DIV1 = 16;
  localparam int unsigned HALF_DIV2 = 8;
  localparam int unsigned HALF_DIV3 = 4;

  // Sample-strobe period per sampling select, in mainclk cycles
  localparam int unsigned SAMP_DIV0 = 64;
  localparam int unsigned SAMP_DIV1 = 32;
  localparam int unsigned SAMP_DIV2 = 16;
  localparam int unsigned SAMP_DIV3 = 8;

  function automatic int unsigned min4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int unsigned HALF_MIN  = min4(HALF_DIV0, HALF_DIV1, HALF_DIV2, HALF_DIV3);
  localparam int unsigned HALF_MAX  = max4(HALF_DIV0, HALF_DIV1, HALF_DIV2, HALF_DIV3);
  localparam int unsigned SAMP_MIN  = min4(SAMP_DIV0, SAMP_DIV1, SAMP_DIV2, SAMP_DIV3);
  localparam int unsigned SAMP_MAX  = max4(SAMP_DIV0, SAMP_DIV1, SAMP_DIV2, SAMP_DIV3);
  localparam int unsigned DIV_LIMIT = 32'd1 << CNT_W;

  function automatic cnt_t half_div(input logic [1:0] sel);
    case (sel)
      2'd0:    return cnt_t'(HALF_DIV0);
      2'd1:    return cnt_t'(HALF_DIV1);
      2'd2:    return cnt_t'(HALF_DIV2);
      default: return cnt_t'(HALF_DIV3);
    endcase
  endfunction

  function automatic cnt_t samp_div(input logic [1:0] sel);
    case (sel)
      2'd0:    return cnt_t'(SAMP_DIV0);
      2'd1:    return cnt_t'(SAMP_DIV1);
      2'd2:    return cnt_t'(SAMP_DIV2);
      default: return cnt_t'(SAMP_DIV3);
    endcase
  endfunction

endpackage

// File: rtl/tx_burst_gen_if.sv
// Sequencer-facing control inputs and transducer/ADC-facing outputs of the burst generator.
interface tx_burst_gen_if;
  logic       enable;
  logic       transmitterOn;
  logic       triggerOn;
  logic [1:0] frequency;
  logic [1:0] sampling;
  logic       txP;
  logic       txN;
  logic       txActive;
  logic       sampleStrobe;
  logic       trigOut;
  logic       burstDone;

  // Sequencer / bench side
  modport master (
    output enable, transmitterOn, triggerOn, frequency, sampling,
    input  txP, txN, txActive, sampleStrobe, trigOut, burstDone
  );

  // Burst generator side
  modport slave (
    input  enable, transmitterOn, triggerOn, frequency, sampling,
    output txP, txN, txActive, sampleStrobe, trigOut, burstDone
  );
endinterface

// File: rtl/div_strobe.sv
// Up-counter 0..period-1 with synchronous clear and count enable; wrap is high in the
// last count of each period while enabled.
module div_strobe #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [Width-1:0] period,
  output logic [Width-1:0] cnt,
  output logic             wrap
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == period - One);
  assign wrap   = en && at_end;
  assign cnt    = cnt_q;

  // Clear has priority; otherwise advance and fold back to zero at the end of the period
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_end ? '0 : cnt_q + One;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_burst_gen.sv
// Transducer burst generator: at each pulse-repetition start it optionally fires a burst of
// complementary drive pulses with dead time, then strobes the ADC until the next start.
module tx_burst_gen
  import dop_tx_pkg::*;
#(
  parameter int unsigned PRF_DIV      = 6400,
  parameter int unsigned BURST_CYCLES = 8,
  parameter int unsigned DEAD         = 2
) (
  input logic          mainclk,
  input logic          reset,
  tx_burst_gen_if.slave bus
);

  // Configuration sanity checks, evaluated at elaboration
  if (DEAD >= HALF_MIN) begin : gen_chk_dead
    $error("DEAD must be smaller than every half period");
  end
  if (2 * BURST_CYCLES * HALF_MAX >= PRF_DIV) begin : gen_chk_burst
    $error("longest burst must fit inside one PRF period");
  end
  if (PRF_DIV < 1 || PRF_DIV >= DIV_LIMIT || BURST_CYCLES < 1 ||
      2 * BURST_CYCLES >= DIV_LIMIT || HALF_MIN < 1 || HALF_MAX >= DIV_LIMIT ||
      SAMP_MIN < 1 || SAMP_MAX >= DIV_LIMIT) begin : gen_chk_range
    $error("divider out of range for CNT_W");
  end

  localparam cnt_t PrfPeriod = cnt_t'(PRF_DIV);
  localparam cnt_t DeadCnt   = cnt_t'(DEAD);
  localparam cnt_t LastHalf  = cnt_t'(2 * BURST_CYCLES - 1);
  localparam cnt_t OneCnt    = cnt_t'(1);

  state_t     state_q, state_d;
  logic [1:0] freq_sel_q, samp_sel_q;
  cnt_t       half_idx_q;
  cnt_t       prf_cnt, half_cnt, samp_cnt;
  cnt_t       half_period, samp_period;
  logic       prf_wrap_unused, half_wrap, samp_wrap;
  logic       in_burst, in_listen, phase;
  logic       prf_expiry, prf_start, burst_end;
  logic       prf_clear, half_clear, half_en, samp_clear, samp_en;
  logic       tx_p_q, tx_n_q, tx_active_q, sample_q, trig_q, done_q;

  assign in_burst    = (state_q == StBurst);
  assign in_listen   = (state_q == StListen);
  assign phase       = half_idx_q[0];
  assign half_period = half_div(freq_sel_q);
  assign samp_period = samp_div(samp_sel_q);

  // Elapsed-count form of the PRF timer: zero is the expiry point, so an idle counter
  // (held at zero) expires on the first enabled cycle.
  assign prf_clear  = !bus.enable;
  assign prf_expiry = bus.enable && (prf_cnt == '0);
  assign prf_start  = prf_expiry && !in_burst;

  assign half_clear = !(in_burst && bus.enable);
  assign half_en    = in_burst && bus.enable;
  assign burst_end  = half_wrap && (half_idx_q == LastHalf);

  // Sample counter restarts on every PRF start, including LISTEN -> LISTEN
  assign samp_clear = !(in_listen && bus.enable) || prf_start;
  assign samp_en    = in_listen && bus.enable;

  div_strobe #(.Width(CNT_W)) u_prf_div (
    .clk    (mainclk),
    .rst    (reset),
    .clear  (prf_clear),
    .en     (bus.enable),
    .period (PrfPeriod),
    .cnt    (prf_cnt),
    .wrap   (prf_wrap_unused)
  );

  div_strobe #(.Width(CNT_W)) u_half_div (
    .clk    (mainclk),
    .rst    (reset),
    .clear  (half_clear),
    .en     (half_en),
    .period (half_period),
    .cnt    (half_cnt),
    .wrap   (half_wrap)
  );

  div_strobe #(.Width(CNT_W)) u_samp_div (
    .clk    (mainclk),
    .rst    (reset),
    .clear  (samp_clear),
    .en     (samp_en),
    .period (samp_period),
    .cnt    (samp_cnt),
    .wrap   (samp_wrap)
  );

  // Next state: enable low always returns to idle; PRF expiry during a burst is ignored
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StListen: if (prf_start) state_d = bus.transmitterOn ? StBurst : StListen;
        StBurst:          if (burst_end) state_d = StListen;
        default:          state_d = StIdle;
      endcase
    end
  end

  // State register
  always_ff @(posedge mainclk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Selects are sampled only at PRF start so a running burst/listen keeps its timing
  always_ff @(posedge mainclk or posedge reset) begin
    if (reset) begin
      freq_sel_q <= 2'd0;
      samp_sel_q <= 2'd0;
    end else if (prf_start) begin
      freq_sel_q <= bus.frequency;
      samp_sel_q <= bus.sampling;
    end
  end

  // Half-period index within the burst; bit 0 is the drive phase
  always_ff @(posedge mainclk or posedge reset) begin
    if (reset) begin
      half_idx_q <= '0;
    end else if (half_clear) begin
      half_idx_q <= '0;
    end else if (half_wrap) begin
      half_idx_q <= half_idx_q + OneCnt;
    end
  end

  // Registered outputs, forced low while disabled (abandoned bursts report no done)
  always_ff @(posedge mainclk or posedge reset) begin
    if (reset || !bus.enable) begin
      tx_p_q      <= 1'b0;
      tx_n_q      <= 1'b0;
      tx_active_q <= 1'b0;
      sample_q    <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      tx_p_q      <= in_burst && !phase && (half_cnt >= DeadCnt);
      tx_n_q      <= in_burst && phase && (half_cnt >= DeadCnt);
      tx_active_q <= in_burst;
      sample_q    <= samp_wrap;
      trig_q      <= prf_start && bus.triggerOn;
      done_q      <= burst_end;
    end
  end

  assign bus.txP          = tx_p_q;
  assign bus.txN          = tx_n_q;
  assign bus.txActive     = tx_active_q;
  assign bus.sampleStrobe = sample_q;
  assign bus.trigOut      = trig_q;
  assign bus.burstDone    = done_q;

  // samp_cnt is observed only through samp_wrap
  logic [CNT_W-1:0] samp_cnt_unused;
  assign samp_cnt_unused = samp_cnt;

endmodule

// File: tb/tb_tx_burst_gen.sv
// Directed bench for tx_burst_gen: per-PRF event counts from a vector table plus
// hand-written sequences for waveform shape, select latching, enable drop and reset.
module tb_tx_burst_gen;

  logic mainclk = 1'b0;
  logic reset   = 1'b0;

  tx_burst_gen_if bus ();

  tx_burst_gen #(
    .PRF_DIV      (6400),
    .BURST_CYCLES (8),
    .DEAD         (2)
  ) dut (
    .mainclk (mainclk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 mainclk = ~mainclk;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;

  typedef struct {
    logic       tx_on;
    logic       trig_on;
    logic [1:0] freq;
    logic [1:0] samp;
    int         act;
    int         p;
    int         n;
    int         trig;
    int         done;
    int         strobes;
  } vec_t;

  vec_t vecs[4];

  // Drives may never overlap
  always @(negedge mainclk) if (bus.txP && bus.txN) overlap++;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int outs();
    return int'({bus.trigOut, bus.txActive, bus.txP, bus.txN, bus.burstDone,
                 bus.sampleStrobe});
  endfunction

  // Disable for a couple of clocks, apply selects, then raise enable at a negedge
  task automatic start(input logic tx_on, input logic trig_on, input logic [1:0] f,
                       input logic [1:0] s);
    @(negedge mainclk);
    bus.enable = 1'b0;
    repeat (2) @(negedge mainclk);
    bus.transmitterOn = tx_on;
    bus.triggerOn     = trig_on;
    bus.frequency     = f;
    bus.sampling      = s;
    bus.enable        = 1'b1;
  endtask

  initial begin
    int c_act, c_p, c_n, c_trig, c_done, c_str;
    int rise, trig_at, acts1, acts2, p1, p2, quiet;

    vecs[0] = '{1'b1, 1'b1, 2'd2, 2'd3, 128, 48,  48,  1, 1, 784};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 2'd0, 512, 240, 240, 0, 1, 92};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 2'd2, 0,   0,   0,   1, 0, 400};
    vecs[3] = '{1'b1, 1'b1, 2'd3, 2'd1, 64,  16,  16,  1, 1, 198};

    bus.enable        = 1'b0;
    bus.transmitterOn = 1'b0;
    bus.triggerOn     = 1'b0;
    bus.frequency     = 2'd0;
    bus.sampling      = 2'd0;

    // Reset state
    #1 reset = 1'b1;
    #2 check("reset_outputs", outs(), 0);
    repeat (2) @(negedge mainclk);
    reset = 1'b0;
    repeat (3) @(negedge mainclk);
    check("idle_outputs", outs(), 0);

    // Event counts over one PRF period (samples 1..6400 after the enabling edge)
    for (int v = 0; v < 4; v++) begin
      start(vecs[v].tx_on, vecs[v].trig_on, vecs[v].freq, vecs[v].samp);
      @(negedge mainclk);
      check($sformatf("v%0d_first_trig", v), int'(bus.trigOut), int'(vecs[v].trig_on));
      c_act = 0; c_p = 0; c_n = 0; c_trig = 0; c_done = 0; c_str = 0;
      for (int i = 1; i <= 6400; i++) begin
        @(negedge mainclk);
        c_act  += int'(bus.txActive);
        c_p    += int'(bus.txP);
        c_n    += int'(bus.txN);
        c_trig += int'(bus.trigOut);
        c_done += int'(bus.burstDone);
        c_str  += int'(bus.sampleStrobe);
      end
      check($sformatf("v%0d_txActive", v), c_act, vecs[v].act);
      check($sformatf("v%0d_txP", v), c_p, vecs[v].p);
      check($sformatf("v%0d_txN", v), c_n, vecs[v].n);
      check($sformatf("v%0d_trigOut", v), c_trig, vecs[v].trig);
      check($sformatf("v%0d_burstDone", v), c_done, vecs[v].done);
      check($sformatf("v%0d_strobes", v), c_str, vecs[v].strobes);
    end

    // Cycle-exact first burst at HALF=8, sampling DIV 8, then PRF spacing
    start(1'b1, 1'b1, 2'd2, 2'd3);
    for (int i = 0; i <= 140; i++) begin
      int  n;
      logic act, ph, drv;
      @(negedge mainclk);
      n   = i - 1;
      act = (i >= 1) && (i <= 128);
      ph  = act && (((n / 8) % 2) == 1);
      drv = act && ((n % 8) >= 2);
      check($sformatf("burst_wave[%0d]", i), outs(),
            int'({i == 0, act, drv && !ph, drv && ph, i == 128,
                  (i >= 129) && (((i - 129) % 8) == 7)}));
    end
    rise = -1; trig_at = -1;
    for (int i = 141; i <= 6500; i++) begin
      @(negedge mainclk);
      if (trig_at < 0 && bus.trigOut)  trig_at = i;
      if (rise < 0 && bus.txActive)    rise = i;
    end
    check("next_trig_at", trig_at, 6400);
    check("next_burst_at", rise, 6401);

    // Frequency change mid-burst only affects the following burst
    start(1'b1, 1'b0, 2'd2, 2'd3);
    @(negedge mainclk);
    acts1 = 0; acts2 = 0; p1 = 0; p2 = 0;
    for (int i = 1; i <= 7000; i++) begin
      @(negedge mainclk);
      if (i == 50) bus.frequency = 2'd0;
      if (i <= 6400) begin
        acts1 += int'(bus.txActive);
        p1    += int'(bus.txP);
      end else begin
        acts2 += int'(bus.txActive);
        p2    += int'(bus.txP);
      end
    end
    check("fchg_burst1_len", acts1, 128);
    check("fchg_burst1_txP", p1, 48);
    check("fchg_burst2_len", acts2, 512);
    check("fchg_burst2_txP", p2, 240);

    // Enable drop mid-burst abandons it silently; re-enable starts a PRF next clock
    start(1'b1, 1'b1, 2'd2, 2'd3);
    repeat (21) @(negedge mainclk);
    check("pre_drop_active", int'(bus.txActive), 1);
    bus.enable = 1'b0;
    @(negedge mainclk);
    check("drop_outputs", outs(), 0);
    quiet = 0;
    repeat (10) begin
      @(negedge mainclk);
      quiet |= outs();
    end
    check("drop_quiet", quiet, 0);
    bus.enable = 1'b1;
    @(negedge mainclk);
    check("reenable_trig", outs(), 32);
    @(negedge mainclk);
    check("reenable_active", int'(bus.txActive), 1);

    // Asynchronous reset mid-burst, outputs stay low until enable returns
    start(1'b1, 1'b1, 2'd2, 2'd3);
    repeat (6) @(negedge mainclk);
    check("pre_reset_txP", int'(bus.txP), 1);
    #2 reset = 1'b1;
    #1 check("async_reset", outs(), 0);
    bus.enable = 1'b0;
    @(negedge mainclk);
    reset = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(negedge mainclk);
      quiet |= outs();
    end
    check("post_reset_quiet", quiet, 0);
    bus.enable = 1'b1;
    @(negedge mainclk);
    check("post_reset_trig", outs(), 32);

    check("no_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_burst_gen.md
Name: tx_burst_gen

Overview:
Downstream stage of the command-sequencer state machine. Consumes its per-step control outputs (frequency, transmitterOn, sampling, triggerOn) and produces the ultrasound transducer drive: complementary burst pulses with dead time at a pulse-repetition interval, then ADC sample strobes during the receive window. Sits between the sequencer and the transmitter pulser / ADC capture logic. Single clock domain: mainclk.

Parameters:
CNT_W, 16, width of all internal counters
PRF_DIV, 6400, pulse-repetition period in mainclk cycles
BURST_CYCLES, 8, transmit periods per burst
DEAD, 2, dead-time clocks at the start of every half-period, with both drives low
HALF_DIV0..HALF_DIV3, 32/16/8/4, half-period in clocks for frequency select 0..3
SAMP_DIV0..SAMP_DIV3, 64/32/16/8, sample-strobe period for sampling select 0..3

Ports:
mainclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run/feedback from sequencer; low forces IDLE
transmitterOn  in  1  1 = transmit burst each PRF; 0 = receive-only
triggerOn  in  1  emit trigOut at each PRF start
frequency  in  2  half-period select
sampling  in  2  sample-period select
txP  out  1  positive drive
txN  out  1  negative drive
txActive  out  1  high while state == BURST
sampleStrobe  out  1  one-clock ADC strobe
trigOut  out  1  one-clock pulse at PRF start
burstDone  out  1  one-clock pulse on BURST->LISTEN

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; latched selects 0. Async assert, synchronous release on mainclk.
- All outputs are registered. txP and txN are never both 1 (bench assertion).
- PRF counter: held at 0 in IDLE. While enable is high it counts down and reloads PRF_DIV-1 after reaching 0. "Expiry" means count == 0 with enable high.
- IDLE: when enable is high, the next clock is a PRF start (the counter is already 0).
- PRF start (expiry in IDLE or LISTEN): latch frequency and sampling. trigOut = triggerOn for one clock. Next state is BURST if transmitterOn, else LISTEN.
- PRF expiry during BURST: ignored (counter still reloads). The burst always completes. The next burst starts at the following expiry.
- BURST:
  - Half-period counter runs 0..HALF_DIV[sel]-1 and toggles the phase bit at wrap. Phase 0 drives txP; phase 1 drives txN.
  - Within each half, the drive is 0 for counts 0..DEAD-1 and 1 for counts DEAD..HALF-1.
  - After 2*BURST_CYCLES halves: go to LISTEN and pulse burstDone.
  - Total BURST length = 2*BURST_CYCLES*HALF clocks.
- LISTEN:
  - Sample counter starts at 0 on entry. sampleStrobe = 1 when count == SAMP_DIV[sel]-1, then the counter wraps.
  - The first strobe is SAMP_DIV clocks after entry.
  - Stays in LISTEN until the next PRF start.
- Select changes on frequency/sampling take effect only at the next PRF start.
- enable falling (any state): next clock is IDLE with all outputs 0. A partial burst is abandoned and burstDone is not pulsed.
- Latency: output registers reflect state one clock after the state change. txP first rises DEAD clocks after the first BURST cycle.
- Elaboration checks: DEAD < min(HALF_DIVn); 2*BURST_CYCLES*max(HALF_DIVn) < PRF_DIV; all dividers ≥ 1 and < 2^CNT_W.
- Arithmetic: all counters unsigned CNT_W bits with no overflow. Divider lookup is a 4-way mux on the latched select.

Decomposition:
- Package dop_tx_pkg holds:
  - state enum {IDLE, BURST, LISTEN}
  - functions half_div(sel) and samp_div(sel) returning CNT_W values
  - the elaboration-check constants
- One sub-module, div_strobe: CNT_W counter with period input, clear, and enable, producing a wrap pulse. It is instantiated for the PRF counter, the half-period counter, and the sample strobe.

Test Plan:
- Reset mid-BURST -> txP/txN/txActive 0 immediately (async); after release, outputs stay 0 until enable is high.
- enable=1, transmitterOn=1, frequency=2 (HALF=8), triggerOn=1 ->
  - trigOut pulses once
  - txP high 6 clocks, low 2, then txN high 6 clocks, low 2; repeated 8 times (128 clocks)
  - burstDone pulses once
  - next burst starts exactly 6400 clocks after the first
- LISTEN with sampling=3 (DIV 8) -> first sampleStrobe 8 clocks after burstDone, then every 8 clocks; count per PRF = floor((6400-128)/8) = 784.
- transmitterOn=0 -> no txP/txN activity ever; LISTEN entered at each PRF start; strobes continue.
- Change frequency 2->0 mid-burst -> current burst keeps HALF=8; next burst uses HALF=32 (total 512 clocks).
- Drop enable mid-burst -> IDLE next clock, no burstDone; re-raise enable -> PRF start on the following clock.
